pwm_capture_avalon: RTL and testbench

- Avalon-MM peripheral that measures period and high time on up to 16 PWM-style inputs.
- Sits downstream of the PWM output stage. It loops back the generated pwm lines, or external pulse trains, so software can verify frequency and duty.
- Register map and prescaler address match the PWM output block, so both use the same driver layout.

---
 rtl/pwm_capture_avalon_if.sv | 19 +
 rtl/pwm_capture_avalon.sv | 167 ++++++++++++++++
 tb/tb_pwm_capture_avalon.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_avalon_if.sv
// Avalon-MM slave command bus for the pulse capture block: word address, strobes and
// a registered read data return.
interface pwm_capture_avalon_if;
   logic [4:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, read, write, writedata,
      input  readdata
   );

   modport slave (
      input  address, read, write, writedata,
      output readdata
   );
endinterface

// File: rtl/pwm_capture_avalon.sv
// Measures period and high time on up to 16 asynchronous pulse inputs in prescaled ticks,
// exposing results, sticky VALID/OVERFLOW flags and a level interrupt over Avalon-MM.
module pwm_capture_avalon #(
   parameter int unsigned NUMBER_INPUTS = 4,
   parameter int unsigned COUNTER_WIDTH = 16,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                     clock_clk,
   input  logic                     reset_reset_n,
   pwm_capture_avalon_if.slave      s0_command,
   input  logic [NUMBER_INPUTS-1:0] pwm_in,
   output logic                     irq
);
   localparam int unsigned N  = NUMBER_INPUTS;
   localparam int unsigned CW = COUNTER_WIDTH;

   localparam logic [4:0] ADDR_VALID     = 5'd16;
   localparam logic [4:0] ADDR_PRESCALER = 5'd17;
   localparam logic [4:0] ADDR_CONTROL   = 5'd18;
   localparam logic [4:0] ADDR_OVERFLOW  = 5'd19;

   typedef enum logic [1:0] {StIdle, StArmed, StHigh, StLow} state_e;

   logic [31:0] prescaler, pcnt, pdiv, rdata;
   logic        enable, irq_en, tick;
   logic        wr_prescaler, wr_control, wr_valid, wr_overflow;
   logic [N-1:0] valid, overflow, done, sat, lvl, lvl_prev;
   logic [N-1:0] sync_pipe [SYNC_STAGES];
   logic [31:0]  ch_word [16];

   always_comb begin
      wr_prescaler = s0_command.write && (s0_command.address == ADDR_PRESCALER);
      wr_control   = s0_command.write && (s0_command.address == ADDR_CONTROL);
      wr_valid     = s0_command.write && (s0_command.address == ADDR_VALID);
      wr_overflow  = s0_command.write && (s0_command.address == ADDR_OVERFLOW);
      // Prescaler values 0 and 1 both give a tick every clock.
      pdiv = (prescaler == 32'd0) ? 32'd0 : prescaler - 32'd1;
      tick = enable && (pcnt >= pdiv);
   end

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         prescaler <= '0;
         pcnt      <= '0;
         enable    <= 1'b0;
         irq_en    <= 1'b0;
         valid     <= '0;
         overflow  <= '0;
      end else begin
         if (wr_prescaler) prescaler <= s0_command.writedata;
         if (wr_control) begin
            enable <= s0_command.writedata[0];
            irq_en <= s0_command.writedata[1];
         end
         if (wr_prescaler || !enable || tick) pcnt <= '0;
         else pcnt <= pcnt + 32'd1;
         // Hardware set is ORed in after the clear so it wins a same-clock race.
         valid    <= (valid & ~({N{wr_valid}} & s0_command.writedata[N-1:0])) | done;
         overflow <= (overflow & ~({N{wr_overflow}} & s0_command.writedata[N-1:0])) | sat;
      end
   end

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_pipe[s] <= '0;
         lvl_prev <= '0;
      end else begin
         sync_pipe[0] <= pwm_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_pipe[s] <= sync_pipe[s-1];
         lvl_prev <= sync_pipe[SYNC_STAGES-1];
      end
   end

   assign lvl = sync_pipe[SYNC_STAGES-1];

   for (genvar i = 0; i < 16; i++) begin : g_ch
      if (i < N) begin : g_on
         state_e        state;
         logic [CW-1:0] per_cnt, high_cnt, per_cap, high_cap;
         logic          rise, fall, sat_ch, done_ch;

         always_comb begin
            rise    = lvl[i] & ~lvl_prev[i];
            fall    = ~lvl[i] & lvl_prev[i];
            sat_ch  = ((state == StHigh) || (state == StLow)) && tick && (per_cnt == {CW{1'b1}});
            done_ch = (state == StLow) && enable && rise && !sat_ch;
         end

         assign sat[i]     = sat_ch;
         assign done[i]    = done_ch;
         assign ch_word[i] = {16'(high_cap), 16'(per_cap)};

         always_ff @(posedge clock_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
               state    <= StIdle;
               per_cnt  <= '0;
               high_cnt <= '0;
               per_cap  <= '0;
               high_cap <= '0;
            end else if (!enable) begin
               state    <= StIdle;
               per_cnt  <= '0;
               high_cnt <= '0;
            end else begin
               unique case (state)
                  StIdle: state <= StArmed;
                  StArmed: begin
                     if (rise) begin
                        per_cnt  <= '0;
                        high_cnt <= '0;
                        state    <= StHigh;
                     end
                  end
                  StHigh: begin
                     if (sat_ch) begin
                        state <= StArmed;
                     end else begin
                        if (tick) begin
                           per_cnt  <= per_cnt + CW'(1);
                           high_cnt <= high_cnt + CW'(1);
                        end
                        if (fall) state <= StLow;
                     end
                  end
                  StLow: begin
                     if (sat_ch) begin
                        state <= StArmed;
                     end else if (rise) begin
                        // A coincident tick still belongs to the interval being closed.
                        per_cap  <= per_cnt + CW'(tick);
                        high_cap <= high_cnt;
                        per_cnt  <= '0;
                        high_cnt <= '0;
                        state    <= StHigh;
                     end else if (tick) begin
                        per_cnt <= per_cnt + CW'(1);
                     end
                  end
                  default: state <= StIdle;
               endcase
            end
         end
      end else begin : g_off
         assign ch_word[i] = '0;
      end
   end

   always_comb begin
      rdata = '0;
      case (s0_command.address)
         ADDR_VALID:     rdata = 32'(valid);
         ADDR_PRESCALER: rdata = prescaler;
         ADDR_CONTROL:   rdata = {30'd0, irq_en, enable};
         ADDR_OVERFLOW:  rdata = 32'(overflow);
         default: begin
            if (!s0_command.address[4]) rdata = ch_word[s0_command.address[3:0]];
         end
      endcase
   end

   always_ff @(posedge clock_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) s0_command.readdata <= '0;
      else if (s0_command.read) s0_command.readdata <= rdata;
   end

   assign irq = irq_en & ((|valid) | (|overflow));
endmodule

// File: tb/tb_pwm_capture_avalon.sv
// Bench for pwm_capture_avalon: register vector table, directed capture sequences, and
// randomized waveforms scored by counting prescaled ticks between edge timestamps.
module tb_pwm_capture_avalon;
   localparam int unsigned NIN  = 4;
   localparam int unsigned SYNC = 2;

   typedef struct {
      bit          wr;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } reg_vec_t;

   logic           clk   = 1'b0;
   logic           rst_n = 1'b0;
   logic [NIN-1:0] pins  = '0;
   logic           irq;
   int             cyc      = 0;
   int             wr_cyc   = 0;
   int             checks   = 0;
   int             failures = 0;
   reg_vec_t       vecs [20];

   pwm_capture_avalon_if bus ();

   pwm_capture_avalon #(
      .NUMBER_INPUTS(NIN),
      .COUNTER_WIDTH(16),
      .SYNC_STAGES  (SYNC)
   ) dut (
      .clock_clk    (clk),
      .reset_reset_n(rst_n),
      .s0_command   (bus),
      .pwm_in       (pins),
      .irq          (irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address   = a;
      bus.writedata = d;
      bus.write     = 1'b1;
      wr_cyc        = cyc + 1;
      @(negedge clk);
      bus.write = 1'b0;
   endtask

   task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
      @(negedge clk);
      bus.address = a;
      bus.read    = 1'b1;
      @(negedge clk);
      bus.read = 1'b0;
      d        = bus.readdata;
   endtask

   task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(a, d);
      check(name, d, exp);
   endtask

   // Holds pin ch at v for n sampled clocks.
   task automatic drive(input int ch, input logic v, input int n);
      @(negedge clk);
      pins[ch] = v;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic restart(input logic [31:0] p);
      bus_write(5'd18, 32'd0);
      pins = '0;
      hold(SYNC + 3);
      bus_write(5'd16, 32'hFFFF);
      bus_write(5'd19, 32'hFFFF);
      bus_write(5'd18, 32'd3);
      bus_write(5'd17, p);
      hold(3);
   endtask

   // Ticks land on clocks w+P, w+2P, ... after the prescaler write sampled at clock w.
   function automatic int ticks(input int w, input int p, input int a, input int b);
      return (b - w) / p - (a - w) / p;
   endfunction

   initial begin
      logic [31:0] rd;
      bus.address   = '0;
      bus.read      = 1'b0;
      bus.write     = 1'b0;
      bus.writedata = '0;
      hold(3);
      rst_n = 1'b1;
      check("reset_irq", 32'(irq), 32'd0);

      vecs[0]  = '{1'b0, 5'd0,  32'h0,        32'h0};
      vecs[1]  = '{1'b0, 5'd16, 32'h0,        32'h0};
      vecs[2]  = '{1'b0, 5'd17, 32'h0,        32'h0};
      vecs[3]  = '{1'b0, 5'd18, 32'h0,        32'h0};
      vecs[4]  = '{1'b0, 5'd19, 32'h0,        32'h0};
      vecs[5]  = '{1'b1, 5'd17, 32'hDEADBEEF, 32'h0};
      vecs[6]  = '{1'b0, 5'd17, 32'h0,        32'hDEADBEEF};
      vecs[7]  = '{1'b1, 5'd18, 32'hFFFFFFFC, 32'h0};
      vecs[8]  = '{1'b0, 5'd18, 32'h0,        32'h0};
      vecs[9]  = '{1'b1, 5'd18, 32'h2,        32'h0};
      vecs[10] = '{1'b0, 5'd18, 32'h0,        32'h2};
      vecs[11] = '{1'b1, 5'd0,  32'h12345678, 32'h0};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        32'h0};
      vecs[13] = '{1'b1, 5'd25, 32'hFFFFFFFF, 32'h0};
      vecs[14] = '{1'b0, 5'd25, 32'h0,        32'h0};
      vecs[15] = '{1'b0, 5'd5,  32'h0,        32'h0};
      vecs[16] = '{1'b1, 5'd17, 32'h0,        32'h0};
      vecs[17] = '{1'b0, 5'd17, 32'h0,        32'h0};
      vecs[18] = '{1'b1, 5'd18, 32'h0,        32'h0};
      vecs[19] = '{1'b0, 5'd18, 32'h0,        32'h0};
      for (int i = 0; i < 20; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].data);
         end else begin
            bus_read(vecs[i].addr, rd);
            check($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
            @(negedge clk);
            check($sformatf("readdata_hold%0d", i), bus.readdata, vecs[i].exp);
         end
      end

      // Basic capture: 10 high / 90 low at one tick per clock.
      restart(32'd1);
      drive(0, 1'b1, 10);
      drive(0, 1'b0, 90);
      drive(0, 1'b1, 1);
      hold(6);
      rd_check("basic_ch0", 5'd0, 32'h000A0064);
      rd_check("basic_valid", 5'd16, 32'h1);
      check("basic_irq", 32'(irq), 32'd1);

      // Prescale by 4: 40/360 clocks gives 10/100 ticks.
      restart(32'd4);
      drive(0, 1'b1, 40);
      drive(0, 1'b0, 360);
      drive(0, 1'b1, 1);
      hold(6);
      rd_check("presc_ch0", 5'd0, 32'h000A0064);
      rd_check("presc_valid", 5'd16, 32'h1);
      bus_write(5'd16, 32'h1);
      rd_check("clear_valid", 5'd16, 32'h0);
      check("clear_irq", 32'(irq), 32'd0);

      // Write-1-clear lands in the same clock as the completing rising edge.
      drive(0, 1'b0, 20);
      @(negedge clk);
      pins[0] = 1'b1;
      repeat (SYNC) @(negedge clk);
      bus.address   = 5'd16;
      bus.writedata = 32'h1;
      bus.write     = 1'b1;
      @(negedge clk);
      bus.write = 1'b0;
      rd_check("race_valid", 5'd16, 32'h1);

      // Disable mid-HIGH, toggle while disabled, then re-enable from ARMED.
      restart(32'd1);
      drive(0, 1'b1, 10);
      drive(0, 1'b0, 90);
      drive(0, 1'b1, 1);
      hold(3);
      bus_write(5'd18, 32'd2);
      drive(0, 1'b0, 5);
      drive(0, 1'b1, 5);
      drive(0, 1'b0, 5);
      drive(0, 1'b1, 5);
      hold(4);
      rd_check("disabled_ch0", 5'd0, 32'h000A0064);
      bus_write(5'd18, 32'd3);
      hold(3);
      drive(0, 1'b0, 4);
      drive(0, 1'b1, 7);
      drive(0, 1'b0, 13);
      rd_check("rearm_ch0", 5'd0, 32'h000A0064);
      drive(0, 1'b1, 1);
      hold(6);
      rd_check("reenable_ch0", 5'd0, 32'h00070016);

      // Constant-high input on channel 1 saturates after 65535 ticks.
      restart(32'd1);
      drive(1, 1'b1, 1);
      hold(65500);
      rd_check("ovf_early", 5'd19, 32'h0);
      hold(60);
      rd_check("ovf_set", 5'd19, 32'h2);
      rd_check("ovf_ch1", 5'd1, 32'h0);
      rd_check("ovf_valid", 5'd16, 32'h0);
      check("ovf_irq", 32'(irq), 32'd1);
      drive(1, 1'b0, 3);
      drive(1, 1'b1, 5);
      drive(1, 1'b0, 5);
      drive(1, 1'b1, 1);
      hold(6);
      rd_check("ovf_restart_ch1", 5'd1, 32'h0005000A);
      rd_check("ovf_sticky", 5'd19, 32'h2);
      bus_write(5'd19, 32'h2);
      rd_check("ovf_clear", 5'd19, 32'h0);

      // Randomized waveforms on all channels against the tick-count model.
      for (int it = 0; it < 6; it++) begin
         int pr, w, total, j, eh, ep;
         int hi [NIN];
         int lo [NIN];
         int off [NIN];
         int kp [NIN];
         int nr [NIN];
         int nf [NIN];
         int rt [NIN][4];
         int ft [NIN][4];
         logic v;
         pr = $urandom_range(1, 4);
         restart(32'(pr));
         w     = wr_cyc;
         total = 0;
         for (int ch = 0; ch < NIN; ch++) begin
            hi[ch]  = $urandom_range(1, 30);
            lo[ch]  = $urandom_range(1, 30);
            off[ch] = $urandom_range(4, 20);
            kp[ch]  = $urandom_range(2, 3);
            nr[ch]  = 0;
            nf[ch]  = 0;
            if (off[ch] + kp[ch] * (hi[ch] + lo[ch]) > total)
               total = off[ch] + kp[ch] * (hi[ch] + lo[ch]);
         end
         for (int t = 0; t <= total; t++) begin
            @(negedge clk);
            for (int ch = 0; ch < NIN; ch++) begin
               v = 1'b0;
               if (t >= off[ch] && t < off[ch] + kp[ch] * (hi[ch] + lo[ch]))
                  v = ((t - off[ch]) % (hi[ch] + lo[ch])) < hi[ch];
               if (v != pins[ch]) begin
                  if (v) begin
                     rt[ch][nr[ch]] = cyc + 1 + SYNC;
                     nr[ch]++;
                  end else begin
                     ft[ch][nf[ch]] = cyc + 1 + SYNC;
                     nf[ch]++;
                  end
               end
               pins[ch] = v;
            end
         end
         hold(SYNC + 4);
         for (int ch = 0; ch < NIN; ch++) begin
            j  = nr[ch] - 2;
            eh = ticks(w, pr, rt[ch][j], ft[ch][j]);
            ep = ticks(w, pr, rt[ch][j], rt[ch][j+1]);
            rd_check($sformatf("rand%0d_ch%0d_p%0d", it, ch, pr), 5'(ch),
                     32'((eh << 16) | ep));
         end
         rd_check($sformatf("rand%0d_valid", it), 5'd16, 32'hF);
         rd_check($sformatf("rand%0d_ovf", it), 5'd19, 32'h0);
         check($sformatf("rand%0d_irq", it), 32'(irq), 32'd1);
      end

      // Reset in the middle of a measurement.
      restart(32'd1);
      drive(0, 1'b1, 6);
      drive(0, 1'b0, 4);
      @(negedge clk);
      rst_n = 1'b0;
      hold(2);
      rst_n = 1'b1;
      for (int a = 0; a < 20; a++) rd_check($sformatf("rst_addr%0d", a), 5'(a), 32'h0);
      check("rst_irq", 32'(irq), 32'd0);
      bus_write(5'd18, 32'd3);
      bus_write(5'd17, 32'd1);
      hold(3);
      drive(0, 1'b1, 6);
      drive(0, 1'b0, 4);
      rd_check("rst_first_edge_valid", 5'd16, 32'h0);
      drive(0, 1'b1, 1);
      hold(6);
      rd_check("rst_second_edge_ch0", 5'd0, 32'h0006000C);
      rd_check("rst_second_edge_valid", 5'd16, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
